// File: rtl/packet_filter.sv
// packet_filter: store-and-forward Avalon-ST filter. Whole packets are buffered
// and forwarded only when the channel on the endofpacket beat equals
// PASS_CHANNEL. Optional macro PACKET_FILTER_STATS_EN adds pass/drop counters.
module packet_filter #(
  parameter int AST_DWIDTH = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int DEPTH = 256,
  parameter int unsigned PASS_CHANNEL = 1,
  localparam int EMPTY_WIDTH = ($clog2(AST_DWIDTH/8) > 0) ? $clog2(AST_DWIDTH/8) : 1
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
`ifdef PACKET_FILTER_STATS_EN
  output logic [31:0]              cnt_pass_o,
  output logic [31:0]              cnt_drop_o,
`endif
  input  logic [AST_DWIDTH-1:0]    ast_sink_data,
  input  logic                     ast_sink_valid,
  output logic                     ast_sink_ready,
  input  logic                     ast_sink_startofpacket,
  input  logic                     ast_sink_endofpacket,
  input  logic [EMPTY_WIDTH-1:0]   ast_sink_empty,
  input  logic [CHANNEL_WIDTH-1:0] ast_sink_channel,
  output logic [AST_DWIDTH-1:0]    ast_src_data,
  output logic                     ast_src_valid,
  input  logic                     ast_src_ready,
  output logic                     ast_src_startofpacket,
  output logic                     ast_src_endofpacket,
  output logic [EMPTY_WIDTH-1:0]   ast_src_empty,
  output logic [CHANNEL_WIDTH-1:0] ast_src_channel
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = AST_DWIDTH + 2 + EMPTY_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [CHANNEL_WIDTH-1:0] PASS_CH = CHANNEL_WIDTH'(PASS_CHANNEL);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} wstate_t;

  wstate_t         state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]   mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [WW-1:0]   mem_wdata;
  logic            start_full, cur_full, pass_match;
  logic            pass_inc;
  logic [1:0]      drop_inc;
  logic            rd_en, rd_empty, pop;
  logic [1:0]      occ_next;
  logic            rd_valid_q, rd_valid_d;
  logic [WW-1:0]   rd_word_q;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [WW-1:0]   out_word_q, out_word_d, skid_word_q, skid_word_d;
  logic            out_sop, out_eop;

  assign ast_sink_ready = ~srst_i;

  // Write FSM: speculative writes, commit on a passing eop, rewind on drop.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q[AW-1:0];
    mem_wdata    = {ast_sink_data, ast_sink_startofpacket, ast_sink_endofpacket, ast_sink_empty};
    pass_inc     = 1'b0;
    drop_inc     = 2'd0;
    pass_match   = (ast_sink_channel == PASS_CH);
    // A new packet always begins at commit_ptr (in IDLE wr_ptr equals it).
    start_full   = ((commit_ptr_q - rd_ptr_q) == DEPTH_P);
    cur_full     = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    if (ast_sink_valid) begin
      case (state_q)
        IDLE, RECV: begin
          if (ast_sink_startofpacket) begin
            if (state_q == RECV) drop_inc = drop_inc + 2'd1;  // previous packet lost its eop
            if (start_full) begin
              wr_ptr_d = commit_ptr_q;
              drop_inc = drop_inc + 2'd1;
              state_d  = ast_sink_endofpacket ? IDLE : DISCARD;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = commit_ptr_q[AW-1:0];
              if (ast_sink_endofpacket) begin
                state_d = IDLE;
                if (pass_match) begin
                  commit_ptr_d = commit_ptr_q + PW'(1);
                  wr_ptr_d     = commit_ptr_q + PW'(1);
                  pass_inc     = 1'b1;
                end else begin
                  wr_ptr_d = commit_ptr_q;
                  drop_inc = drop_inc + 2'd1;
                end
              end else begin
                wr_ptr_d = commit_ptr_q + PW'(1);
                state_d  = RECV;
              end
            end
          end else if (state_q == RECV) begin
            if (cur_full) begin
              wr_ptr_d = commit_ptr_q;
              drop_inc = 2'd1;
              state_d  = ast_sink_endofpacket ? IDLE : DISCARD;
            end else begin
              mem_we = 1'b1;
              if (ast_sink_endofpacket) begin
                state_d = IDLE;
                if (pass_match) begin
                  commit_ptr_d = wr_ptr_q + PW'(1);
                  wr_ptr_d     = wr_ptr_q + PW'(1);
                  pass_inc     = 1'b1;
                end else begin
                  wr_ptr_d = commit_ptr_q;
                  drop_inc = 2'd1;
                end
              end else begin
                wr_ptr_d = wr_ptr_q + PW'(1);
              end
            end
          end
        end
        DISCARD: if (ast_sink_endofpacket) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Read side: prefetch from RAM only when the output/skid pair can absorb it.
  always_comb begin
    rd_empty     = (rd_ptr_q == commit_ptr_q);
    pop          = out_valid_q & ast_src_ready;
    occ_next     = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_valid_q) - 2'(pop);
    rd_en        = !rd_empty && (occ_next <= 2'd1);
    rd_ptr_d     = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    rd_valid_d   = rd_en;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_word_d   = skid_word_q;
        skid_valid_d = rd_valid_q;
        if (rd_valid_q) skid_word_d = rd_word_q;
      end else if (rd_valid_q) begin
        out_valid_d = 1'b1;
        out_word_d  = rd_word_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (rd_valid_q) begin
      skid_valid_d = 1'b1;
      skid_word_d  = rd_word_q;
    end
  end

  // Buffer RAM with registered read port; no reset so it maps to block RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en)  rd_word_q <= mem[rd_ptr_q[AW-1:0]];
  end

  // State, pointer and output-stage registers.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      rd_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_word_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_valid_q   <= rd_valid_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
    end
  end

  assign {ast_src_data, out_sop, out_eop, ast_src_empty} = out_word_q;
  assign ast_src_valid         = out_valid_q;
  assign ast_src_startofpacket = out_valid_q & out_sop;
  assign ast_src_endofpacket   = out_valid_q & out_eop;
  assign ast_src_channel       = out_valid_q ? PASS_CH : '0;

`ifdef PACKET_FILTER_STATS_EN
  logic [31:0] cnt_pass_q, cnt_pass_d, cnt_drop_q, cnt_drop_d;
  logic [32:0] drop_sum;

  // Saturating packet counters.
  always_comb begin
    cnt_pass_d = (pass_inc && (cnt_pass_q != '1)) ? cnt_pass_q + 32'd1 : cnt_pass_q;
    drop_sum   = {1'b0, cnt_drop_q} + 33'(drop_inc);
    cnt_drop_d = drop_sum[32] ? '1 : drop_sum[31:0];
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      cnt_pass_q <= '0;
      cnt_drop_q <= '0;
    end else begin
      cnt_pass_q <= cnt_pass_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  assign cnt_pass_o = cnt_pass_q;
  assign cnt_drop_o = cnt_drop_q;
`else
  logic unused_stats;
  assign unused_stats = ^{pass_inc, drop_inc};
`endif

endmodule

// File: tb/tb_packet_filter.sv
// Directed testbench for packet_filter (DEPTH=4, 32-bit data, PASS_CHANNEL=1).
module tb_packet_filter;
  localparam int DW = 32;
  localparam int EW = 2;

  typedef logic [DW+EW+2:0] word_t;  // {channel, sop, eop, empty, data}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sink_data = '0;
  logic          sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic [EW-1:0] sink_empty = '0;
  logic [0:0]    sink_channel = '0;
  logic          sink_ready;
  logic [DW-1:0] src_data;
  logic          src_valid, src_sop, src_eop;
  logic          src_ready = 1'b1;
  logic [EW-1:0] src_empty;
  logic [0:0]    src_channel;
`ifdef PACKET_FILTER_STATS_EN
  logic [31:0]   cnt_pass, cnt_drop;
`endif

  int    checks = 0;
  int    errors = 0;
  word_t got_q[$];
  word_t exp_q[$];
  word_t prev_word = '0;
  logic  prev_stall = 1'b0;

  always #5 clk = ~clk;

  packet_filter #(.AST_DWIDTH(DW), .CHANNEL_WIDTH(1), .DEPTH(4), .PASS_CHANNEL(1)) dut (
    .clk_i(clk), .srst_i(rst),
`ifdef PACKET_FILTER_STATS_EN
    .cnt_pass_o(cnt_pass), .cnt_drop_o(cnt_drop),
`endif
    .ast_sink_data(sink_data), .ast_sink_valid(sink_valid), .ast_sink_ready(sink_ready),
    .ast_sink_startofpacket(sink_sop), .ast_sink_endofpacket(sink_eop),
    .ast_sink_empty(sink_empty), .ast_sink_channel(sink_channel),
    .ast_src_data(src_data), .ast_src_valid(src_valid), .ast_src_ready(src_ready),
    .ast_src_startofpacket(src_sop), .ast_src_endofpacket(src_eop),
    .ast_src_empty(src_empty), .ast_src_channel(src_channel)
  );

  // Output monitor: records transfers and checks hold-stability during stalls.
  always @(negedge clk) begin
    word_t cur;
    cur = {src_channel, src_sop, src_eop, src_empty, src_data};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        assert ({src_valid, cur} === {1'b1, prev_word}) else begin
          errors++;
          $error("FAIL stall_hold: observed %h expected %h", {src_valid, cur}, {1'b1, prev_word});
        end
      end
      if (src_valid && src_ready) begin
        got_q.push_back(cur);
        $display("src transfer: data=%h sop=%0b eop=%0b empty=%0d ch=%0d",
                 src_data, src_sop, src_eop, src_empty, src_channel);
      end
      prev_stall = src_valid && !src_ready;
      prev_word  = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                      input logic [EW-1:0] emp, input logic ch);
    sink_valid = 1'b1; sink_data = d; sink_sop = sop; sink_eop = eop;
    sink_empty = emp; sink_channel = ch;
    @(posedge clk); #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic sop, input logic eop,
                             input logic [EW-1:0] emp);
    exp_q.push_back({1'b1, sop, eop, emp, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the expected words, optionally toggling ready 1,0,0,1.
  task automatic drain(input string tag, input bit toggle);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin
      if (toggle) src_ready = pat[n % 4];
      @(posedge clk); #1;
      n++;
    end
    src_ready = 1'b1;
    idle(6);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_stats(input string tag, input int p, input int d);
`ifdef PACKET_FILTER_STATS_EN
    check({tag, "_cnt_pass"}, 64'(cnt_pass), 64'(p));
    check({tag, "_cnt_drop"}, 64'(cnt_drop), 64'(d));
`else
    if (p < 0 || d < 0) $display("bad stats arguments for %s", tag);
`endif
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_valid", src_valid, 0);
    check("rst_sop", src_sop, 0);
    check("rst_eop", src_eop, 0);
    check("rst_data", src_data, 0);
    check("rst_empty", src_empty, 0);
    check("rst_channel", src_channel, 0);
    check("rst_sink_ready", sink_ready, 0);
    check_stats("rst", 0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("sink_ready_run", sink_ready, 1);

    // T1: 4-word passing packet (exactly DEPTH words), latency 2 after eop
    beat(32'hA000_0000, 1, 0, 0, 0);
    beat(32'hA000_0001, 0, 0, 0, 0);
    beat(32'hA000_0002, 0, 0, 0, 0);
    beat(32'hA000_0003, 0, 1, 2, 1);
    check("t1_lat_n0", src_valid, 0);
    @(posedge clk); #1;
    check("t1_lat_n1", src_valid, 0);
    @(posedge clk); #1;
    check("t1_lat_n2_valid", src_valid, 1);
    check("t1_lat_n2_sop", src_sop, 1);
    check("t1_lat_n2_data", src_data, 32'hA000_0000);
    expect_word(32'hA000_0000, 1, 0, 0);
    expect_word(32'hA000_0001, 0, 0, 0);
    expect_word(32'hA000_0002, 0, 0, 0);
    expect_word(32'hA000_0003, 0, 1, 2);
    drain("t1", 0);
    check("t1_idle_valid", src_valid, 0);
    check("t1_idle_channel", src_channel, 0);
    check_stats("t1", 1, 0);

    // T2: 3-word packet with channel 0 on eop is dropped; next passes intact
    beat(32'hB000_0000, 1, 0, 0, 1);
    beat(32'hB000_0001, 0, 0, 0, 1);
    beat(32'hB000_0002, 0, 1, 1, 0);
    idle(10);
    check("t2_drop_count", 64'(got_q.size()), 0);
    beat(32'hC000_0000, 1, 0, 0, 0);
    beat(32'hC000_0001, 0, 1, 3, 1);
    expect_word(32'hC000_0000, 1, 0, 0);
    expect_word(32'hC000_0001, 0, 1, 3);
    drain("t2", 0);
    check_stats("t2", 2, 1);

    // T3: 6-word packet overflows DEPTH=4 and is dropped; 2-word packet follows
    for (int i = 0; i < 6; i++)
      beat(32'hD000_0000 + DW'(i), logic'(i == 0), logic'(i == 5), 0, 1);
    beat(32'hE000_0000, 1, 0, 0, 0);
    beat(32'hE000_0001, 0, 1, 2, 1);
    expect_word(32'hE000_0000, 1, 0, 0);
    expect_word(32'hE000_0001, 0, 1, 2);
    drain("t3", 0);
    check_stats("t3", 3, 2);

    // T4: sop at beat 3 abandons the unfinished packet
    beat(32'hF000_0000, 1, 0, 0, 1);
    beat(32'hF000_0001, 0, 0, 0, 1);
    beat(32'h6000_0000, 1, 0, 0, 0);
    beat(32'h6000_0001, 0, 1, 1, 1);
    expect_word(32'h6000_0000, 1, 0, 0);
    expect_word(32'h6000_0001, 0, 1, 1);
    drain("t4", 0);
    check_stats("t4", 4, 3);

    // T5: back-to-back passing packets, ready toggling 1,0,0,1
    src_ready = 1'b0;
    beat(32'h7000_0000, 1, 0, 0, 1);
    beat(32'h7000_0001, 0, 1, 1, 1);
    beat(32'h8000_0000, 1, 0, 0, 1);
    beat(32'h8000_0001, 0, 1, 2, 1);
    expect_word(32'h7000_0000, 1, 0, 0);
    expect_word(32'h7000_0001, 0, 1, 1);
    expect_word(32'h8000_0000, 1, 0, 0);
    expect_word(32'h8000_0001, 0, 1, 2);
    drain("t5", 1);
    check_stats("t5", 6, 3);

    // T7: single-beat packets, one passing and one failing
    beat(32'h9000_0000, 1, 1, 3, 1);
    beat(32'h9100_0000, 1, 1, 0, 0);
    expect_word(32'h9000_0000, 1, 1, 3);
    drain("t7", 0);
    check_stats("t7", 7, 4);

    // T6: reset during output, then a fresh packet
    beat(32'h5000_0000, 1, 0, 0, 0);
    beat(32'h5000_0001, 0, 0, 0, 0);
    beat(32'h5000_0002, 0, 0, 0, 0);
    beat(32'h5000_0003, 0, 1, 0, 1);
    for (int n = 0; n < 50 && got_q.size() < 2; n++) idle(1);
    check("t6_mid_valid", src_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", src_valid, 0);
    check("t6_rst_sop", src_sop, 0);
    check("t6_rst_eop", src_eop, 0);
    check("t6_rst_data", src_data, 0);
    check("t6_rst_empty", src_empty, 0);
    check("t6_rst_channel", src_channel, 0);
    check("t6_rst_sink_ready", sink_ready, 0);
    check_stats("t6_rst", 0, 0);
    idle(2);
    got_q.delete();
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    beat(32'h4000_0000, 1, 0, 0, 0);
    beat(32'h4000_0001, 0, 0, 0, 0);
    beat(32'h4000_0002, 0, 1, 1, 1);
    expect_word(32'h4000_0000, 1, 0, 0);
    expect_word(32'h4000_0001, 0, 0, 0);
    expect_word(32'h4000_0002, 0, 1, 1);
    drain("t6", 0);
    check_stats("t6", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
